arbitro_vc_wrr: RTL



---
 rtl/arbitro_vc_wrr.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/arbitro_vc_wrr.sv
// Purpose : weighted round-robin scheduler sharing one output mux between VC0 and VC1 FIFOs.
// Latency : pops are combinational; mux_sel/mux_valid follow each pop by exactly one cycle.
// Backpr. : D0_pause or D1_pause freezes all pops (HOLD); the partial quantum resumes afterwards.
//
// Ports:
//   clk, reset_L            - clock (rising edge) and asynchronous active-low reset
//   VC0_empty, VC1_empty    - VC FIFO empty flags
//   D0_pause, D1_pause      - downstream almost-full; either one stalls the scheduler
//   VC0_pop, VC1_pop        - combinational pop strobes, never both high
//   mux_sel, mux_valid      - registered select (0=VC0, 1=VC1) and valid, aligned to FIFO read data
//   arb_state               - IDLE=0, SRV0=1, SRV1=2, HOLD=3
//
// Optional build macro ARB_STRICT_PRIO_EN: VC0 gets strict priority; weights and the
// quantum counter are unused. VC1 is served only while VC0 is empty.

module arbitro_vc_wrr #(
    parameter int WEIGHT0 = 4,
    parameter int WEIGHT1 = 1,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       VC0_empty,
    input  logic       VC1_empty,
    input  logic       D0_pause,
    input  logic       D1_pause,
    output logic       VC0_pop,
    output logic       VC1_pop,
    output logic       mux_sel,
    output logic       mux_valid,
    output logic [1:0] arb_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRV0 = 2'd1,
        SRV1 = 2'd2,
        HOLD = 2'd3
    } state_t;

`ifndef ARB_STRICT_PRIO_EN
    // Counter value of the last pop in a quantum.
    localparam logic [CNT_W-1:0] LAST0 = CNT_W'(WEIGHT0 - 1);
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'(WEIGHT1 - 1);
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_next_vc;
    logic             r_resume_vc;
    logic             r_mux_sel;
    logic             r_mux_valid;

    logic             w_pause;
    logic             w_pop0;
    logic             w_pop1;

    assign w_pause = D0_pause | D1_pause;

    // Gated by reset_L so the strobes drop the instant reset asserts, before any edge.
    assign w_pop0 = reset_L & (r_state == SRV0) & ~VC0_empty & ~w_pause;
    assign w_pop1 = reset_L & (r_state == SRV1) & ~VC1_empty & ~w_pause;

    assign VC0_pop   = w_pop0;
    assign VC1_pop   = w_pop1;
    assign mux_sel   = r_mux_sel;
    assign mux_valid = r_mux_valid;
    assign arb_state = r_state;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_next_vc   <= 1'b0;
            r_resume_vc <= 1'b0;
            r_mux_sel   <= 1'b0;
            r_mux_valid <= 1'b0;
        end else begin
            // Mux controls line up with the FIFO's one-cycle read latency.
            r_mux_valid <= w_pop0 | w_pop1;
            if (w_pop0 | w_pop1) begin
                r_mux_sel <= w_pop1;
            end

            case (r_state)
                IDLE: begin
                    if (w_pause) begin
                        r_state     <= HOLD;
                        r_resume_vc <= r_next_vc;
`ifdef ARB_STRICT_PRIO_EN
                    end else if (!VC0_empty) begin
                        r_state <= SRV0;
                        r_cnt   <= '0;
                    end else if (!VC1_empty) begin
                        r_state <= SRV1;
                        r_cnt   <= '0;
                    end
`else
                    // Preferred VC first, then the other one.
                    end else if (r_next_vc ? !VC1_empty : !VC0_empty) begin
                        r_state <= r_next_vc ? SRV1 : SRV0;
                        r_cnt   <= '0;
                    end else if (r_next_vc ? !VC0_empty : !VC1_empty) begin
                        r_state <= r_next_vc ? SRV0 : SRV1;
                        r_cnt   <= '0;
                    end
`endif
                end

                SRV0: begin
                    if (w_pause) begin
                        // Counter held so the quantum resumes where it stopped.
                        r_state     <= HOLD;
                        r_resume_vc <= 1'b0;
`ifndef ARB_STRICT_PRIO_EN
                    end else if (w_pop0 && (r_cnt == LAST0)) begin
                        // Quantum expired; with VC1 empty a fresh VC0 quantum starts.
                        r_cnt     <= '0;
                        r_next_vc <= 1'b1;
                        r_state   <= !VC1_empty ? SRV1 : SRV0;
`endif
                    end else if (VC0_empty) begin
                        r_cnt     <= '0;
                        r_next_vc <= 1'b1;
                        r_state   <= !VC1_empty ? SRV1 : IDLE;
                    end else begin
`ifndef ARB_STRICT_PRIO_EN
                        if (w_pop0) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
`endif
                    end
                end

                SRV1: begin
                    if (w_pause) begin
                        r_state     <= HOLD;
                        r_resume_vc <= 1'b1;
`ifdef ARB_STRICT_PRIO_EN
                    end else if (!VC0_empty) begin
                        // VC0 preempts; a VC1 pop in this cycle still completes.
                        r_next_vc <= 1'b0;
                        r_state   <= SRV0;
`else
                    end else if (w_pop1 && (r_cnt == LAST1)) begin
                        r_cnt     <= '0;
                        r_next_vc <= 1'b0;
                        r_state   <= !VC0_empty ? SRV0 : SRV1;
`endif
                    end else if (VC1_empty) begin
                        r_cnt     <= '0;
                        r_next_vc <= 1'b0;
                        r_state   <= !VC0_empty ? SRV0 : IDLE;
                    end else begin
`ifndef ARB_STRICT_PRIO_EN
                        if (w_pop1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
`endif
                    end
                end

                HOLD: begin
                    if (!w_pause) begin
`ifdef ARB_STRICT_PRIO_EN
                        r_state <= (!VC0_empty || !r_resume_vc) ? SRV0 : SRV1;
`else
                        // Counter untouched: the interrupted quantum continues.
                        r_state <= r_resume_vc ? SRV1 : SRV0;
`endif
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
